// File: rtl/mcs4_bus_fabric_if.sv
// Bus-fabric interface: agent drive/enable, cycle marker and the resolved/monitor outputs.
// master = agent/system side, slave = the fabric itself.
interface mcs4_bus_fabric_if #(
   parameter int unsigned NUM_AGENTS = 8,
   parameter int unsigned DATA_W     = 4,
   parameter int unsigned CNT_W      = 8
);
   localparam int unsigned OWN_W = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;

   logic [NUM_AGENTS*DATA_W-1:0] agent_data;
   logic [NUM_AGENTS-1:0]        agent_en;
   logic                         sync;
   logic                         clear_errors;
   logic [DATA_W-1:0]            bus;
   logic [OWN_W-1:0]             bus_owner;
   logic                         bus_busy;
   logic [2:0]                   phase;
   logic                         locked;
   logic                         contention;
   logic [CNT_W-1:0]             contention_count;
   logic                         sync_error;
   logic [3*DATA_W-1:0]          cycle_addr;
   logic                         addr_valid;
   logic [2*DATA_W-1:0]          instr;
   logic                         instr_valid;

   modport master (
      output agent_data, agent_en, sync, clear_errors,
      input  bus, bus_owner, bus_busy, phase, locked, contention, contention_count,
             sync_error, cycle_addr, addr_valid, instr, instr_valid
   );

   modport slave (
      input  agent_data, agent_en, sync, clear_errors,
      output bus, bus_owner, bus_busy, phase, locked, contention, contention_count,
             sync_error, cycle_addr, addr_valid, instr, instr_valid
   );
endinterface

// File: rtl/mcs4_bus_fabric.sv
// MCS-4 style shared-bus fabric: fixed-priority nibble bus resolve, 8-phase cycle
// tracker locked to sync, contention/sync fault monitor and fetch trace capture.
// Optional macro BUS_FABRIC_TRACE_EN compiles in the address/instruction capture;
// without it the trace outputs are tied to 0.
module mcs4_bus_fabric #(
   parameter int unsigned NUM_AGENTS = 8,
   parameter int unsigned DATA_W     = 4,
   parameter int unsigned CNT_W      = 8
) (
   input logic               clock,
   input logic               reset,
   mcs4_bus_fabric_if.slave  bus_if
);
   localparam int unsigned OWN_W = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;

   logic [DATA_W-1:0] bus_val;
   logic [OWN_W-1:0]  owner_val;
   logic              multi_en;
   logic              sync_fault;

   logic [2:0]        phase_q;
   logic              locked_q;
   logic              contention_q;
   logic [CNT_W-1:0]  contention_cnt_q;
   logic              sync_error_q;
   logic [CNT_W-1:0]  sync_err_cnt_q;

   // Lowest enabled index wins; scan downward so the last hit is the highest priority.
   always_comb begin
      bus_val   = '0;
      owner_val = '0;
      for (int k = NUM_AGENTS - 1; k >= 0; k--) begin
         if (bus_if.agent_en[k]) begin
            bus_val   = bus_if.agent_data[k*DATA_W +: DATA_W];
            owner_val = OWN_W'(k);
         end
      end
   end

   assign multi_en   = ($countones(bus_if.agent_en) > 1);
   assign sync_fault = bus_if.sync && locked_q && (phase_q != 3'd7);

   // Phase tracker: sync forces phase 0 and lock; unlocked tracker parks at X3.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase_q  <= 3'd7;
         locked_q <= 1'b0;
      end else if (bus_if.sync) begin
         phase_q  <= 3'd0;
         locked_q <= 1'b1;
      end else if (locked_q) begin
         phase_q  <= phase_q + 3'd1;
      end
   end

   // Sticky fault flags and saturating counters; a same-clock event beats the clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         contention_q     <= 1'b0;
         contention_cnt_q <= '0;
         sync_error_q     <= 1'b0;
         sync_err_cnt_q   <= '0;
      end else if (bus_if.clear_errors) begin
         contention_q     <= multi_en;
         contention_cnt_q <= multi_en ? CNT_W'(1) : '0;
         sync_error_q     <= sync_fault;
         sync_err_cnt_q   <= sync_fault ? CNT_W'(1) : '0;
      end else begin
         if (multi_en) begin
            contention_q <= 1'b1;
            if (contention_cnt_q != '1) contention_cnt_q <= contention_cnt_q + CNT_W'(1);
         end
         if (sync_fault) begin
            sync_error_q <= 1'b1;
            if (sync_err_cnt_q != '1) sync_err_cnt_q <= sync_err_cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef BUS_FABRIC_TRACE_EN
   logic [2*DATA_W-1:0] addr_part_q;
   logic [DATA_W-1:0]   opr_q;
   logic [3*DATA_W-1:0] cycle_addr_q;
   logic [2*DATA_W-1:0] instr_q;
   logic                addr_valid_q;
   logic                instr_valid_q;

   // Fetch capture; a sync on any capture phase restarts the cycle, dropping the partial.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_part_q   <= '0;
         opr_q         <= '0;
         cycle_addr_q  <= '0;
         instr_q       <= '0;
         addr_valid_q  <= 1'b0;
         instr_valid_q <= 1'b0;
      end else begin
         addr_valid_q  <= 1'b0;
         instr_valid_q <= 1'b0;
         if (locked_q && !bus_if.sync) begin
            case (phase_q)
               3'd0: addr_part_q[DATA_W-1:0]        <= bus_val;
               3'd1: addr_part_q[2*DATA_W-1:DATA_W] <= bus_val;
               3'd2: begin
                  cycle_addr_q <= {bus_val, addr_part_q};
                  addr_valid_q <= 1'b1;
               end
               3'd3: opr_q <= bus_val;
               3'd4: begin
                  instr_q       <= {opr_q, bus_val};
                  instr_valid_q <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus_if.cycle_addr  = cycle_addr_q;
   assign bus_if.addr_valid  = addr_valid_q;
   assign bus_if.instr       = instr_q;
   assign bus_if.instr_valid = instr_valid_q;
`else
   assign bus_if.cycle_addr  = '0;
   assign bus_if.addr_valid  = 1'b0;
   assign bus_if.instr       = '0;
   assign bus_if.instr_valid = 1'b0;
`endif

   assign bus_if.bus              = bus_val;
   assign bus_if.bus_owner        = owner_val;
   assign bus_if.bus_busy         = |bus_if.agent_en;
   assign bus_if.phase            = phase_q;
   assign bus_if.locked           = locked_q;
   assign bus_if.contention       = contention_q;
   assign bus_if.contention_count = contention_cnt_q;
   assign bus_if.sync_error       = sync_error_q;
endmodule

// File: tb/tb_mcs4_bus_fabric.sv
// Self-checking bench for mcs4_bus_fabric: directed scenarios plus randomized traffic
// checked against a cycle-counting reference model. Honours BUS_FABRIC_TRACE_EN.
module tb_mcs4_bus_fabric;
   localparam int unsigned NA = 8;
   localparam int unsigned DW = 4;
   localparam int unsigned CW = 8;
   localparam int unsigned OW = $clog2(NA);
`ifdef BUS_FABRIC_TRACE_EN
   localparam bit TRACE = 1'b1;
`else
   localparam bit TRACE = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state
   int              m_elapsed;  // clocks since the last sync edge, -1 when unlocked
   int              m_cnt;
   bit              m_cont, m_serr, m_av, m_iv;
   logic [DW-1:0]   m_s [8];
   logic [3*DW-1:0] m_addr;
   logic [2*DW-1:0] m_instr;

   mcs4_bus_fabric_if #(.NUM_AGENTS(NA), .DATA_W(DW), .CNT_W(CW)) bif ();

   mcs4_bus_fabric #(.NUM_AGENTS(NA), .DATA_W(DW), .CNT_W(CW)) dut (
      .clock  (clock),
      .reset  (reset),
      .bus_if (bif)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   function automatic int mph();
      return (m_elapsed < 0) ? 7 : (m_elapsed % 8);
   endfunction

   function automatic logic [DW-1:0] ref_bus();
      for (int k = 0; k < NA; k++)
         if (bif.agent_en[k]) return bif.agent_data[k*DW +: DW];
      return '0;
   endfunction

   function automatic logic [OW-1:0] ref_owner();
      for (int k = 0; k < NA; k++)
         if (bif.agent_en[k]) return OW'(k);
      return '0;
   endfunction

   function automatic int ref_pop();
      int c = 0;
      for (int k = 0; k < NA; k++) c += int'(bif.agent_en[k]);
      return c;
   endfunction

   task automatic model_reset();
      m_elapsed = -1; m_cnt = 0; m_cont = 0; m_serr = 0; m_av = 0; m_iv = 0;
      m_addr = '0; m_instr = '0;
      for (int i = 0; i < 8; i++) m_s[i] = '0;
   endtask

   task automatic idle_inputs();
      bif.agent_data   = '0;
      bif.agent_en     = '0;
      bif.sync         = 1'b0;
      bif.clear_errors = 1'b0;
   endtask

   task automatic drive_one(input int k, input logic [DW-1:0] d);
      bif.agent_en = '0;
      bif.agent_en[k] = 1'b1;
      bif.agent_data[k*DW +: DW] = d;
   endtask

   // One clock: sample the pre-edge inputs into the model, clock, settle.
   task automatic tick();
      int ph; bit lk, multi, sy, clr, ev; logic [DW-1:0] b;
      ph = mph(); lk = (m_elapsed >= 0); b = ref_bus(); multi = (ref_pop() > 1);
      sy = bif.sync; clr = bif.clear_errors;
      @(posedge clock);
      ev = sy && lk && (ph != 7);
      if (clr) begin
         m_cont = multi; m_cnt = multi ? 1 : 0; m_serr = ev;
      end else begin
         if (multi) begin m_cont = 1; if (m_cnt < 255) m_cnt++; end
         if (ev) m_serr = 1;
      end
      m_av = 0; m_iv = 0;
      if (lk && !sy) begin
         m_s[ph] = b;
         if (ph == 2) begin m_addr = {b, m_s[1], m_s[0]}; m_av = 1; end
         if (ph == 4) begin m_instr = {m_s[3], b}; m_iv = 1; end
      end
      if (sy) m_elapsed = 0;
      else if (m_elapsed >= 0) m_elapsed++;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if (bif.phase !== 3'd7) $display("FAIL reset_phase got %0d want 7", bif.phase); else n_pass++;
      n_checks++; if (bif.locked !== 1'b0) $display("FAIL reset_locked got %0b want 0", bif.locked); else n_pass++;
      n_checks++;
      if ({bif.contention, bif.contention_count, bif.sync_error} !== '0)
         $display("FAIL reset_errors got %0b/%0d/%0b want 0", bif.contention, bif.contention_count, bif.sync_error);
      else n_pass++;
      n_checks++;
      if ({bif.cycle_addr, bif.instr, bif.addr_valid, bif.instr_valid} !== '0)
         $display("FAIL reset_trace got %h/%h/%0b/%0b want 0", bif.cycle_addr, bif.instr, bif.addr_valid, bif.instr_valid);
      else n_pass++;
      n_checks++;
      if ({bif.bus, bif.bus_owner, bif.bus_busy} !== '0)
         $display("FAIL reset_bus got %h/%0d/%0b want 0", bif.bus, bif.bus_owner, bif.bus_busy);
      else n_pass++;
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   // Drive the documented fetch pattern for the given model phase.
   task automatic drive_fetch_phase();
      idle_inputs();
      case (mph())
         0: drive_one(0, 4'h1);
         1: drive_one(0, 4'h2);
         2: drive_one(0, 4'h3);
         3: drive_one(1, 4'hA);
         4: drive_one(1, 4'h5);
         7: bif.sync = 1'b1;
         default: ;
      endcase
   endtask

   task automatic test_fetch_cycle();
      bit seen_addr = 0, seen_instr = 0;
      for (int i = 0; i < 3 * 8 + 1; i++) begin
         drive_fetch_phase();
         tick();
         n_checks++;
         if (bif.phase !== 3'(mph()) || bif.locked !== (m_elapsed >= 0))
            $display("FAIL fetch_phase got %0d/%0b want %0d/%0b", bif.phase, bif.locked, mph(), m_elapsed >= 0);
         else n_pass++;
         n_checks++;
         if (bif.addr_valid !== (TRACE & m_av) || bif.instr_valid !== (TRACE & m_iv))
            $display("FAIL fetch_valid got %0b/%0b want %0b/%0b", bif.addr_valid, bif.instr_valid, TRACE & m_av, TRACE & m_iv);
         else n_pass++;
         if (TRACE && bif.phase == 3'd3) begin
            seen_addr = 1;
            n_checks++;
            if (bif.cycle_addr !== 12'h321 || bif.addr_valid !== 1'b1)
               $display("FAIL fetch_addr got %h/%0b want 321/1", bif.cycle_addr, bif.addr_valid);
            else n_pass++;
         end
         if (TRACE && bif.phase == 3'd5) begin
            seen_instr = 1;
            n_checks++;
            if (bif.instr !== 8'hA5 || bif.instr_valid !== 1'b1)
               $display("FAIL fetch_instr got %h/%0b want a5/1", bif.instr, bif.instr_valid);
            else n_pass++;
         end
         if (!TRACE) begin
            n_checks++;
            if (bif.cycle_addr !== '0 || bif.instr !== '0)
               $display("FAIL fetch_trace_off got %h/%h want 0/0", bif.cycle_addr, bif.instr);
            else n_pass++;
         end
         n_checks++;
         if (bif.contention !== 1'b0) $display("FAIL fetch_contention got %0b want 0", bif.contention); else n_pass++;
      end
      if (TRACE) begin
         n_checks++;
         if (!(seen_addr && seen_instr)) $display("FAIL fetch_seen got %0b/%0b want 1/1", seen_addr, seen_instr);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bif.agent_data = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: bif.agent_en = '0;
            1, 2: begin bif.agent_en = '0; bif.agent_en[$urandom_range(0, NA - 1)] = 1'b1; end
            default: bif.agent_en = NA'($urandom);
         endcase
         bif.sync = ((mph() == 7) && ($urandom_range(0, 7) != 0)) || ($urandom_range(0, 40) == 0);
         bif.clear_errors = ($urandom_range(0, 30) == 0);
         #1;
         n_checks++;
         if (bif.bus !== ref_bus() || bif.bus_owner !== ref_owner() || bif.bus_busy !== (ref_pop() > 0))
            $display("FAIL rand_resolve en=%b got %h/%0d/%0b want %h/%0d/%0b", bif.agent_en,
                     bif.bus, bif.bus_owner, bif.bus_busy, ref_bus(), ref_owner(), ref_pop() > 0);
         else n_pass++;
         tick();
         n_checks++;
         if (bif.phase !== 3'(mph()) || bif.locked !== (m_elapsed >= 0))
            $display("FAIL rand_phase got %0d/%0b want %0d/%0b", bif.phase, bif.locked, mph(), m_elapsed >= 0);
         else n_pass++;
         n_checks++;
         if (bif.contention !== m_cont || bif.contention_count !== CW'(m_cnt) || bif.sync_error !== m_serr)
            $display("FAIL rand_errors got %0b/%0d/%0b want %0b/%0d/%0b", bif.contention,
                     bif.contention_count, bif.sync_error, m_cont, m_cnt, m_serr);
         else n_pass++;
         n_checks++;
         if (bif.addr_valid !== (TRACE & m_av) || bif.instr_valid !== (TRACE & m_iv) ||
             bif.cycle_addr !== (TRACE ? m_addr : '0) || bif.instr !== (TRACE ? m_instr : '0))
            $display("FAIL rand_trace got %h/%0b %h/%0b want %h/%0b %h/%0b", bif.cycle_addr, bif.addr_valid,
                     bif.instr, bif.instr_valid, TRACE ? m_addr : '0, TRACE & m_av, TRACE ? m_instr : '0, TRACE & m_iv);
         else n_pass++;
      end
   endtask

   task automatic test_contention();
      idle_inputs();
      bif.clear_errors = 1'b1;
      tick();
      bif.clear_errors = 1'b0;
      bif.agent_en[2] = 1'b1; bif.agent_data[2*DW +: DW] = 4'h6;
      bif.agent_en[5] = 1'b1; bif.agent_data[5*DW +: DW] = 4'h9;
      #1;
      n_checks++;
      if (bif.bus !== 4'h6 || bif.bus_owner !== 3'd2 || bif.bus_busy !== 1'b1)
         $display("FAIL cont_resolve got %h/%0d/%0b want 6/2/1", bif.bus, bif.bus_owner, bif.bus_busy);
      else n_pass++;
      n_checks++;
      if (bif.contention !== 1'b0) $display("FAIL cont_before got %0b want 0", bif.contention); else n_pass++;
      tick();
      n_checks++;
      if (bif.contention !== 1'b1 || bif.contention_count !== 8'd1)
         $display("FAIL cont_first got %0b/%0d want 1/1", bif.contention, bif.contention_count);
      else n_pass++;
      repeat (299) tick();
      n_checks++;
      if (bif.contention_count !== 8'd255)
         $display("FAIL cont_saturate got %0d want 255", bif.contention_count);
      else n_pass++;
   endtask

   task automatic test_clear_same_clock();
      bif.clear_errors = 1'b1;
      tick();
      bif.clear_errors = 1'b0;
      n_checks++;
      if (bif.contention !== 1'b1 || bif.contention_count !== 8'd1)
         $display("FAIL clear_race got %0b/%0d want 1/1", bif.contention, bif.contention_count);
      else n_pass++;
      bif.agent_en = '0;
      bif.clear_errors = 1'b1;
      tick();
      bif.clear_errors = 1'b0;
      n_checks++;
      if (bif.contention !== 1'b0 || bif.contention_count !== 8'd0)
         $display("FAIL clear_plain got %0b/%0d want 0/0", bif.contention, bif.contention_count);
      else n_pass++;
   endtask

   task automatic test_sync_error();
      idle_inputs();
      bif.clear_errors = 1'b1;
      tick();
      while (mph() != 3) begin
         drive_fetch_phase();
         tick();
      end
      idle_inputs();
      bif.sync = 1'b1;
      tick();
      bif.sync = 1'b0;
      n_checks++;
      if (bif.sync_error !== 1'b1 || bif.phase !== 3'd0)
         $display("FAIL sync_err got %0b/phase %0d want 1/0", bif.sync_error, bif.phase);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         drive_fetch_phase();
         tick();
         n_checks++;
         if (bif.instr_valid !== 1'b0) $display("FAIL sync_abort phase %0d got %0b want 0", bif.phase, bif.instr_valid);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_cycle();
      while (mph() != 4) begin
         drive_fetch_phase();
         tick();
      end
      idle_inputs();
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if (bif.phase !== 3'd7 || bif.locked !== 1'b0)
         $display("FAIL rstmid_phase got %0d/%0b want 7/0", bif.phase, bif.locked);
      else n_pass++;
      n_checks++;
      if ({bif.contention, bif.contention_count, bif.sync_error, bif.cycle_addr, bif.instr,
           bif.addr_valid, bif.instr_valid, bif.bus, bif.bus_owner, bif.bus_busy} !== '0)
         $display("FAIL rstmid_outputs got %0b/%0d/%0b %h/%h not all zero", bif.contention,
                  bif.contention_count, bif.sync_error, bif.cycle_addr, bif.instr);
      else n_pass++;
      #1 reset = 1'b0;
      model_reset();
      tick();
      n_checks++;
      if (bif.phase !== 3'd7 || bif.locked !== 1'b0)
         $display("FAIL rstmid_hold got %0d/%0b want 7/0", bif.phase, bif.locked);
      else n_pass++;
      bif.sync = 1'b1;
      tick();
      bif.sync = 1'b0;
      n_checks++;
      if (bif.phase !== 3'd0 || bif.locked !== 1'b1 || bif.sync_error !== 1'b0)
         $display("FAIL rstmid_relock got %0d/%0b/%0b want 0/1/0", bif.phase, bif.locked, bif.sync_error);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fetch_cycle();
      test_random();
      test_contention();
      test_clear_same_clock();
      test_sync_error();
      test_reset_mid_cycle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
